// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: word handshake between the TX FIFO / bus side
// (master) and the UART transmit engine (slave).
`timescale 1ns/1ps

interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit engine. Accepts a word over a
// valid/ready handshake and serialises start bit, DATA_W data bits (LSB
// first), optional parity and 1 or 2 stop bits on sdo, with bit timing
// from an internal clocks-per-bit divider.
// Optional feature macro: UART_TX_BREAK_EN (adds tx_break input and a
// BREAK state that holds sdo low, followed by one bit time of mark).
`timescale 1ns/1ps

module uart_tx_serializer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_serializer_if.slave tx_bus,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                tx_break,
`endif
  output logic                sdo,
  output logic                busy,
  output logic                tx_done
);

  // Shift register holds every bit after the start bit: data plus one slot
  // that carries parity (or a stop bit when parity is off). It refills with
  // 1s, so the remaining stop bits fall out of it naturally.
  localparam int              FRAME_W   = DATA_W + 1;
  localparam logic [3:0]      DATA_BITS = 4'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1
`ifdef UART_TX_BREAK_EN
    , ST_BREAK = 2'd2
`endif
  } state_t;

  // Parity over the data bits; odd mode inverts the even result.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                      input logic              odd);
    parity_bit = (^data) ^ odd;
  endfunction

  // Bits following the start bit, as loaded into the shift register.
  function automatic logic [FRAME_W-1:0] load_frame(input logic [DATA_W-1:0] data,
                                                    input logic              par_en,
                                                    input logic              odd);
    load_frame = {(par_en ? parity_bit(data, odd) : 1'b1), data};
  endfunction

  state_t             state_r, state_nx;
  logic               sdo_r, sdo_nx;
  logic               busy_r, busy_nx;
  logic               done_r, done_nx;
  logic [FRAME_W-1:0] shift_r, shift_nx;
  logic [3:0]         bits_r, bits_nx;
  logic [DIV_W-1:0]   timer_r, timer_nx;
  logic [DIV_W-1:0]   reload_r, reload_nx;
  logic               mab_r, mab_nx;

  logic               break_req_s;
  logic               tx_ready_s;
  logic               accept_s;
  logic [DIV_W-1:0]   div_eff_s;
  logic [DIV_W-1:0]   div_reload_s;
  logic [3:0]         frame_bits_s;

`ifdef UART_TX_BREAK_EN
  assign break_req_s = tx_break;
`else
  assign break_req_s = 1'b0;
`endif

  // A divider of 0 behaves as 1; the timer counts D-1 down to 0.
  assign div_eff_s    = (baud_div == DIV_ZERO) ? DIV_ONE : baud_div;
  assign div_reload_s = div_eff_s - DIV_ONE;
  // Bits still to send after the start bit: data, parity, stop(s).
  assign frame_bits_s = DATA_BITS + {3'b000, parity_en} + (two_stop ? 4'd2 : 4'd1);

  // Ready in IDLE, or in the very last cycle of the last stop bit so a
  // following word starts with no idle gap; a pending break blocks it.
  always_comb begin
    tx_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: tx_ready_s = ~break_req_s;
      ST_SEND: tx_ready_s = (timer_r == DIV_ZERO) && (bits_r == 4'd0) && ~break_req_s;
      default: tx_ready_s = 1'b0;
    endcase
  end

  assign accept_s       = tx_ready_s & tx_bus.tx_valid;
  assign tx_bus.tx_ready = tx_ready_s;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_nx  = state_r;
    sdo_nx    = sdo_r;
    busy_nx   = busy_r;
    done_nx   = 1'b0;
    shift_nx  = shift_r;
    bits_nx   = bits_r;
    timer_nx  = timer_r;
    reload_nx = reload_r;
    mab_nx    = mab_r;

    case (state_r)
      ST_IDLE: begin
        if (break_req_s) begin
`ifdef UART_TX_BREAK_EN
          state_nx = ST_BREAK;
          sdo_nx   = 1'b0;
          busy_nx  = 1'b1;
          mab_nx   = 1'b0;
`else
          state_nx = ST_IDLE;
          sdo_nx   = 1'b1;
          busy_nx  = 1'b0;
`endif
        end else if (accept_s) begin
          state_nx  = ST_SEND;
          sdo_nx    = 1'b0;
          busy_nx   = 1'b1;
          shift_nx  = load_frame(tx_bus.tx_data, parity_en, parity_odd);
          bits_nx   = frame_bits_s;
          timer_nx  = div_reload_s;
          reload_nx = div_reload_s;
        end else begin
          sdo_nx  = 1'b1;
          busy_nx = 1'b0;
        end
      end

      ST_SEND: begin
        busy_nx = 1'b1;
        if (timer_r != DIV_ZERO) begin
          timer_nx = timer_r - DIV_ONE;
        end else if (bits_r != 4'd0) begin
          sdo_nx   = shift_r[0];
          shift_nx = {1'b1, shift_r[FRAME_W-1:1]};
          bits_nx  = bits_r - 4'd1;
          timer_nx = reload_r;
        end else begin
          done_nx = 1'b1;
          if (accept_s) begin
            state_nx  = ST_SEND;
            sdo_nx    = 1'b0;
            shift_nx  = load_frame(tx_bus.tx_data, parity_en, parity_odd);
            bits_nx   = frame_bits_s;
            timer_nx  = div_reload_s;
            reload_nx = div_reload_s;
          end else begin
            state_nx = ST_IDLE;
            sdo_nx   = 1'b1;
            busy_nx  = 1'b0;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        busy_nx = 1'b1;
        if (!mab_r) begin
          if (tx_break) begin
            sdo_nx = 1'b0;
          end else begin
            mab_nx   = 1'b1;
            sdo_nx   = 1'b1;
            timer_nx = div_reload_s;
          end
        end else if (timer_r != DIV_ZERO) begin
          timer_nx = timer_r - DIV_ONE;
        end else begin
          state_nx = ST_IDLE;
          busy_nx  = 1'b0;
          mab_nx   = 1'b0;
          sdo_nx   = 1'b1;
        end
      end
`endif

      default: begin
        state_nx = ST_IDLE;
        sdo_nx   = 1'b1;
        busy_nx  = 1'b0;
        mab_nx   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line to mark at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      sdo_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      shift_r  <= {FRAME_W{1'b1}};
      bits_r   <= 4'd0;
      timer_r  <= DIV_ZERO;
      reload_r <= DIV_ZERO;
      mab_r    <= 1'b0;
    end else begin
      state_r  <= state_nx;
      sdo_r    <= sdo_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
      shift_r  <= shift_nx;
      bits_r   <= bits_nx;
      timer_r  <= timer_nx;
      reload_r <= reload_nx;
      mab_r    <= mab_nx;
    end
  end

  assign sdo     = sdo_r;
  assign busy    = busy_r;
  assign tx_done = done_r;

endmodule
